// File: rtl/enc_seg_display.sv
// enc_seg_display: shows an 8-bit value on a 4-digit multiplexed 7-segment display.
// A free-running converter turns the value into decimal digits with double-dabble
// (or into hex digits) and publishes all four digits at once. A refresh counter
// then steps through the digits, one at a time.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   disp_val  value to display, 0..255
//   swt       display mode: 0 = decimal, 1 = hexadecimal
//   anode     registered active-low digit enables, bit 0 = rightmost digit
//   seg_out   registered active-low segments {g,f,e,d,c,b,a}
module enc_seg_display #(
  parameter int unsigned DIV_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] disp_val,
  input  logic       swt,
  output logic [3:0] anode,
  output logic [6:0] seg_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  // A digit code is a 4-bit glyph value; bit 4 set means blank.
  localparam logic [4:0] DigBlank = 5'h10;

  state_e             state_q, state_d;
  logic [7:0]         val_q, val_d;      // captured value, used by hex mode
  logic               mode_q, mode_d;    // captured swt
  logic [7:0]         bin_q, bin_d;      // binary bits still to be shifted in
  logic [11:0]        bcd_q, bcd_d;
  logic [2:0]         step_q, step_d;
  logic [3:0][4:0]    dig_q, dig_d;
  logic [DIV_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         anode_q, anode_d;
  logic [6:0]         seg_q, seg_d;

  logic [11:0]        bcd_adj;
  logic [3:0]         hund, tens, ones;

  function automatic logic [6:0] seg_enc(input logic [4:0] dig);
    logic [6:0] seg;
    case (dig)
      5'h00:   seg = 7'b1000000;
      5'h01:   seg = 7'b1111001;
      5'h02:   seg = 7'b0100100;
      5'h03:   seg = 7'b0110000;
      5'h04:   seg = 7'b0011001;
      5'h05:   seg = 7'b0010010;
      5'h06:   seg = 7'b0000010;
      5'h07:   seg = 7'b1111000;
      5'h08:   seg = 7'b0000000;
      5'h09:   seg = 7'b0010000;
      5'h0a:   seg = 7'b0001000;
      5'h0b:   seg = 7'b0000011;
      5'h0c:   seg = 7'b1000110;
      5'h0d:   seg = 7'b0100001;
      5'h0e:   seg = 7'b0000110;
      5'h0f:   seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign hund = bcd_q[11:8];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

  // Converter: IDLE -> LOAD -> SHIFT x8 -> DONE, repeating every 11 clocks.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mode_d  = mode_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    dig_d   = dig_q;
    unique case (state_q)
      StIdle: begin
        state_d = StLoad;
      end
      StLoad: begin
        val_d   = disp_val;
        mode_d  = swt;
        bin_d   = disp_val;
        bcd_d   = '0;
        step_d  = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d  = {bcd_adj[10:0], bin_q[7]};
        bin_d  = {bin_q[6:0], 1'b0};
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // All four digits change together so the display never mixes results.
        dig_d[3] = DigBlank;
        if (mode_q) begin
          dig_d[2] = DigBlank;
          dig_d[1] = {1'b0, val_q[7:4]};
          dig_d[0] = {1'b0, val_q[3:0]};
        end else begin
          dig_d[2] = (hund == 4'd0) ? DigBlank : {1'b0, hund};
          dig_d[1] = (hund == 4'd0 && tens == 4'd0) ? DigBlank : {1'b0, tens};
          dig_d[0] = {1'b0, ones};
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Scan: advance the digit index each time the refresh counter wraps.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (&refresh_q) begin
      idx_d = idx_q + 2'd1;
    end
    anode_d = ~(4'b0001 << idx_q);
    seg_d   = seg_enc(dig_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      val_q     <= '0;
      mode_q    <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      dig_q     <= {4{DigBlank}};
      refresh_q <= '0;
      idx_q     <= '0;
      anode_q   <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      mode_q    <= mode_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      step_q    <= step_d;
      dig_q     <= dig_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign anode   = anode_q;
  assign seg_out = seg_q;

endmodule

// File: doc/enc_seg_display.md
ENC_SEG_DISPLAY -- requirements
Module: enc_seg_display

Interface
REQ-001 Parameter DIV_BITS, default 16: width of the scan-refresh counter; the digit advances every 2^DIV_BITS clocks.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 disp_val  input  8  unsigned value from the rotary-encoder counter stage, 0..255.
REQ-005 swt  input  1  display mode: 0 = decimal, 1 = hexadecimal.
REQ-006 anode  output  4  registered, active-low digit enables; bit 0 = rightmost digit.
REQ-007 seg_out  output  7  registered, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-008 Converter FSM SHALL have states IDLE, LOAD, SHIFT, DONE, and SHALL run continuously: IDLE->LOAD->SHIFT(x8)->DONE->IDLE, one conversion every 11 clocks.
REQ-009 LOAD SHALL capture disp_val and swt together into internal registers; later input changes SHALL NOT affect the conversion in progress.
REQ-010 SHIFT SHALL perform one double-dabble step per clock (add 3 to any BCD nibble >= 5, then shift left 1) over a 12-bit BCD + 8-bit binary register.
REQ-011 DONE SHALL load all four digit registers in the same clock, with no partially updated digit set ever displayed.
REQ-012 Decimal mode: digit3 = blank; digit2 = hundreds, blank if 0; digit1 = tens, blank if hundreds and tens are both 0; digit0 = ones, never blank.
REQ-013 Hex mode: digit3 = blank, digit2 = blank, digit1 = disp_val[7:4], digit0 = disp_val[3:0]; no leading-zero blanking. The BCD result SHALL be ignored in this mode, but the FSM sequence SHALL be unchanged.
REQ-014 A change on disp_val or swt SHALL be reflected in the digit registers within 22 clocks.
REQ-015 The refresh counter SHALL increment every clock and wrap from 2^DIV_BITS-1 to 0; on wrap, the 2-bit scan index SHALL advance 0->1->2->3->0.
REQ-016 Each clock, anode SHALL be registered as all-ones except bit[index]=0, and seg_out SHALL be registered as the encoding of digit[index]; outputs lag the index by 1 clock.
REQ-017 Segment encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
REQ-018 Exactly one anode bit SHALL be low at any time after the first post-reset clock; anode SHALL never be 4'b0000 or have two low bits.
REQ-019 Values 0 and 255 SHALL convert correctly: 0 -> "   0" and 255 -> " 255".

Reset
REQ-020 While rst_n=0, all of the following SHALL hold, asynchronously:
- anode = 4'b1111, seg_out = 7'b1111111
- FSM = IDLE, refresh counter = 0, scan index = 0
- all digit registers = blank
REQ-021 Reset asserted mid-conversion SHALL discard the partial result; the first conversion after release SHALL start from LOAD with the current disp_val.
REQ-022 Until the first DONE after reset, every digit SHALL show blank.

Verification (DIV_BITS=2 in the bench)
REQ-023 Reset, then disp_val=8'd0, swt=0 -> within 22 clocks, digit0 shows 1000000 while anode=1110; the other three digits show 1111111.
REQ-024 disp_val=8'd120, swt=0 -> over one full scan, anode 1110/1101/1011/0111 with seg_out 1000000/0100100/1111001/1111111.
REQ-025 disp_val=8'd255, swt=1 -> digit0 and digit1 both show F (0001110); digit2 and digit3 are blank. Switch to swt=0 -> within 22 clocks: 5, 5, 2, blank.
REQ-026 disp_val changes 8'd99 -> 8'd100 during SHIFT -> the in-flight conversion completes as 99 (" 99"); the next conversion shows "100"; no mixed digit set is observed.
REQ-027 Assert rst_n=0 during SHIFT and while anode=1011 -> anode=1111 and seg_out=1111111 immediately, without waiting for a clock edge. After release, the index restarts at 0 and exactly one anode is low from the second clock onward.
